otp_pgm_seq: RTL and testbench

OTP_PGM_SEQ -- requirements
Module: otp_pgm_seq

---
 rtl/otp_pkg.sv | 45 ++++
 rtl/otp_tmr.sv | 37 +++
 rtl/otp_pgm_seq.sv | 201 ++++++++++++++++++++
 tb/tb_otp_pgm_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
// ---------------------------------------------------------------------------
// otp_pkg -- shared types and constants for the OTP program/read sequencer.
//
// Contents:
//   ADDR_W / DATA_W / IDX_W / OTP_ADDR_W : byte address, data byte, bit index
//                                          and macro address widths
//   CNT_W                                : phase timer width
//   T_*_DEF                              : default phase lengths in cycles
//   state_e                              : sequencer state encoding
//   phase_load()                         : timer reload value for a phase
//
// Optional feature macro used by the sequencer: OTP_PGM_VERIFY_EN.
// ---------------------------------------------------------------------------
package otp_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int IDX_W      = 3;
  localparam int OTP_ADDR_W = ADDR_W + IDX_W;
  localparam int CNT_W      = 16;

  localparam int T_SU_DEF  = 2;
  localparam int T_PGM_DEF = 100;
  localparam int T_HD_DEF  = 2;
  localparam int T_RD_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RSETUP  = 3'd4,
    ST_RSTROBE = 3'd5,
    ST_NEXT    = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

  // A phase of N cycles reloads the down-counter with N-1 and ends when the
  // counter reads zero. A zero-length phase still occupies one cycle.
  function automatic logic [CNT_W-1:0] phase_load(input int unsigned len);
    if (len <= 1) return '0;
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/otp_tmr.sv
// ---------------------------------------------------------------------------
// otp_tmr -- loadable 16-bit down-counter with a zero flag.
//
// Ports:
//   CP          in   clock
//   CDN         in   asynchronous active-low clear
//   load_i      in   load load_val_i this cycle (has priority over counting)
//   load_val_i  in   reload value
//   zero_o      out  counter currently reads zero
//
// The counter holds at zero rather than wrapping.
// ---------------------------------------------------------------------------
module otp_tmr
  import otp_pkg::*;
(
  input  logic             CP,
  input  logic             CDN,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/otp_pgm_seq.sv
// ---------------------------------------------------------------------------
// otp_pgm_seq -- bit-serial program/read sequencer for an OTP macro.
//
// A program request walks bits 0..7 of the data byte, strobing otp_pgm_o for
// each 1 bit (setup, strobe, hold). A read request walks bits 0..7 with a
// read strobe and assembles the sampled bits into rdata_o.
//
// Ports:
//   CP, CDN       clock, asynchronous active-low clear
//   req_i         request strobe (sampled only in IDLE)
//   wr_i          1 = program, 0 = read
//   addr_i        byte address
//   wdata_i       bits to program (1 = blow)
//   busy_o        sequence in progress
//   done_o        one-cycle completion pulse
//   rdata_o       last read byte
//   err_o         verify mismatch, sticky until the next accepted request
//   otp_clk_en_o  enable for the macro clock gate, high while busy
//   otp_addr_o    {addr, bit index} to the macro
//   otp_pgm_o     program strobe
//   otp_rd_o      read strobe
//   otp_q_i       macro read data bit, valid during otp_rd_o
//
// Build option: define OTP_PGM_VERIFY_EN to follow every program pass with a
// read-back of the same byte; err_o flags any requested bit that reads 0.
// Without it err_o is tied low.
// ---------------------------------------------------------------------------
module otp_pgm_seq
  import otp_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_PGM = T_PGM_DEF,
  parameter int T_HD  = T_HD_DEF,
  parameter int T_RD  = T_RD_DEF
) (
  input  logic                  CP,
  input  logic                  CDN,
  input  logic                  req_i,
  input  logic                  wr_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  output logic                  otp_clk_en_o,
  output logic [OTP_ADDR_W-1:0] otp_addr_o,
  output logic                  otp_pgm_o,
  output logic                  otp_rd_o,
  input  logic                  otp_q_i
);

  localparam logic [CNT_W-1:0] LD_SU  = phase_load(T_SU);
  localparam logic [CNT_W-1:0] LD_PGM = phase_load(T_PGM);
  localparam logic [CNT_W-1:0] LD_HD  = phase_load(T_HD);
  localparam logic [CNT_W-1:0] LD_RD  = phase_load(T_RD);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  // Set while walking a read pass (a plain read or the verify read-back).
  logic              rd_pass_q, rd_pass_d;
`ifdef OTP_PGM_VERIFY_EN
  logic              wr_q, wr_d;
  logic              err_q, err_d;
`endif

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_zero;

  otp_tmr u_tmr (
    .CP         (CP),
    .CDN        (CDN),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      idx_q     <= '0;
      rd_pass_q <= 1'b0;
`ifdef OTP_PGM_VERIFY_EN
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      idx_q     <= idx_d;
      rd_pass_q <= rd_pass_d;
`ifdef OTP_PGM_VERIFY_EN
      wr_q      <= wr_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    idx_d     = idx_q;
    rd_pass_d = rd_pass_q;
`ifdef OTP_PGM_VERIFY_EN
    wr_d      = wr_q;
    err_d     = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          idx_d     = '0;
          rd_pass_d = !wr_i;
`ifdef OTP_PGM_VERIFY_EN
          wr_d      = wr_i;
          err_d     = 1'b0;
`endif
          state_d   = wr_i ? ST_SETUP : ST_RSETUP;
        end
      end
      ST_SETUP: begin
        // Bits that stay unblown cost one SETUP cycle and no strobe.
        if (!wdata_q[idx_q]) state_d = ST_NEXT;
        else if (tmr_zero)   state_d = ST_STROBE;
      end
      ST_STROBE: if (tmr_zero) state_d = ST_HOLD;
      ST_HOLD:   if (tmr_zero) state_d = ST_NEXT;
      ST_RSETUP: if (tmr_zero) state_d = ST_RSTROBE;
      ST_RSTROBE: begin
        if (tmr_zero) begin
          rdata_d[idx_q] = otp_q_i;
          state_d        = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q == IDX_W'(7)) begin
`ifdef OTP_PGM_VERIFY_EN
          if (!rd_pass_q) begin
            // Program pass finished: read the byte back before completing.
            rd_pass_d = 1'b1;
            idx_d     = '0;
            state_d   = ST_RSETUP;
          end else begin
            // rdata_q already holds bit 7 here (sampled when RSTROBE ended).
            if (wr_q) err_d = ((rdata_q & wdata_q) != wdata_q);
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = rd_pass_q ? ST_RSETUP : ST_SETUP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reload the phase timer on every state change with the length of the
  // phase being entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    unique case (state_d)
      ST_SETUP, ST_RSETUP: tmr_val = LD_SU;
      ST_STROBE:           tmr_val = LD_PGM;
      ST_HOLD:             tmr_val = LD_HD;
      ST_RSTROBE:          tmr_val = LD_RD;
      default:             tmr_val = '0;
    endcase
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign otp_clk_en_o = (state_q != ST_IDLE);
  assign otp_pgm_o    = (state_q == ST_STROBE);
  assign otp_rd_o     = (state_q == ST_RSTROBE);
  assign otp_addr_o   = {addr_q, idx_q};
  assign rdata_o      = rdata_q;
`ifdef OTP_PGM_VERIFY_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_otp_pgm_seq.sv
// ---------------------------------------------------------------------------
// tb_otp_pgm_seq -- self-checking bench for otp_pgm_seq.
//
// An OTP macro model (byte array, bit blown only by a full-width program
// pulse, optional bit-3 stuck-at-0) answers the read strobes. A reference
// byte array tracks the expected contents at transaction level; timing
// expectations are computed from the phase lengths.
// Honours OTP_PGM_VERIFY_EN to match the build of the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_otp_pgm_seq;

  localparam int TSU  = 2;
  localparam int TPGM = 100;
  localparam int THD  = 2;
  localparam int TRD  = 4;
`ifdef OTP_PGM_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        CP = 1'b0;
  logic        CDN = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  wdata = 8'h00;
  logic        busy, done, err, clk_en, otp_pgm, otp_rd, otp_q;
  logic [7:0]  rdata;
  logic [10:0] otp_addr;

  always #5 CP = ~CP;

  otp_pgm_seq #(.T_SU(TSU), .T_PGM(TPGM), .T_HD(THD), .T_RD(TRD)) dut (
    .CP           (CP),
    .CDN          (CDN),
    .req_i        (req),
    .wr_i         (wr),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .busy_o       (busy),
    .done_o       (done),
    .rdata_o      (rdata),
    .err_o        (err),
    .otp_clk_en_o (clk_en),
    .otp_addr_o   (otp_addr),
    .otp_pgm_o    (otp_pgm),
    .otp_rd_o     (otp_rd),
    .otp_q_i      (otp_q)
  );

  // ---------------- macro model ----------------
  logic [7:0] mem [256] = '{8'h12: 8'h3C, default: 8'h00};
  bit stuck_en = 1'b0;
  assign otp_q = mem[otp_addr[10:3]][otp_addr[2:0]] & !(stuck_en && otp_addr[2:0] == 3'd3);

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge CP) cyc <= cyc + 1;

  int busy_cyc = 0, done_cnt = 0, viol = 0, done_gap = 0, done_last = 0;
  int pgm_bad = 0, rd_bad = 0, rd_cnt = 0, pgm_len = 0, rd_len = 0;
  logic [7:0]  done_rdata = 8'h00;
  logic        done_err = 1'b0;
  logic [10:0] pgm_start = '0, rd_start = '0;
  bit pgm_prev = 1'b0, rd_prev = 1'b0;
  int pgm_addr_q[$];

  always @(negedge CP) begin
    viol <= viol + ((otp_pgm && otp_rd) ? 1 : 0)
                 + (((otp_pgm || otp_rd) && !clk_en) ? 1 : 0)
                 + ((otp_pgm && pgm_prev && otp_addr != pgm_start) ? 1 : 0)
                 + ((otp_rd && rd_prev && otp_addr != rd_start) ? 1 : 0);
    if (busy) busy_cyc <= busy_cyc + 1;
    if (done) begin
      done_cnt   <= done_cnt + 1;
      done_rdata <= rdata;
      done_err   <= err;
      done_gap   <= cyc - done_last;
      done_last  <= cyc;
    end
    if (otp_pgm) begin
      if (!pgm_prev) begin
        pgm_addr_q.push_back(int'(otp_addr));
        pgm_start <= otp_addr;
        pgm_len   <= 1;
      end else begin
        pgm_len <= pgm_len + 1;
      end
    end else if (pgm_prev) begin
      if (pgm_len != TPGM) pgm_bad <= pgm_bad + 1;
      else mem[pgm_start[10:3]][pgm_start[2:0]] <= 1'b1;
    end
    if (otp_rd) begin
      if (!rd_prev) begin
        rd_cnt   <= rd_cnt + 1;
        rd_start <= otp_addr;
        rd_len   <= 1;
      end else begin
        rd_len <= rd_len + 1;
      end
    end else if (rd_prev && rd_len != TRD) begin
      rd_bad <= rd_bad + 1;
    end
    pgm_prev <= otp_pgm;
    rd_prev  <= otp_rd;
  end

  // ---------------- checking ----------------
  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rdata;

  function automatic int m1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int prog_cycles(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++)
      n += d[i] ? (m1(TSU) + m1(TPGM) + m1(THD) + 1) : 2;
    return n;
  endfunction

  function automatic int read_cycles();
    return 8 * (m1(TSU) + m1(TRD) + 1);
  endfunction

  function automatic int seq_cycles(input bit w_r, input logic [7:0] d);
    int n;
    n = w_r ? (prog_cycles(d) + (VERIFY ? read_cycles() : 0)) : read_cycles();
    return n + 1;
  endfunction

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"},   busy,     0);
    check_eq({tag, "_done"},   done,     0);
    check_eq({tag, "_err"},    err,      0);
    check_eq({tag, "_rdata"},  rdata,    0);
    check_eq({tag, "_pgm"},    otp_pgm,  0);
    check_eq({tag, "_rd"},     otp_rd,   0);
    check_eq({tag, "_clken"},  clk_en,   0);
    check_eq({tag, "_addr"},   otp_addr, 0);
  endtask

  task automatic run_op(input bit w_r, input logic [7:0] a, input logic [7:0] d);
    int s_pgm, s_bad, s_rd, s_rbad, s_busy, s_done, s_viol, n_pgm;
    logic [7:0] mask, exp_after;
    logic exp_err;
    int idx_list[$];
    mask      = stuck_en ? 8'hF7 : 8'hFF;
    exp_after = w_r ? (ref_mem[a] | d) : ref_mem[a];
    for (int i = 0; i < 8; i++)
      if (w_r && d[i]) idx_list.push_back(int'({a, i[2:0]}));
    exp_err = VERIFY && w_r && (((exp_after & mask) & d) != d);
    if (!w_r || VERIFY) exp_rdata = exp_after & mask;

    @(posedge CP); #1;
    s_pgm = pgm_addr_q.size(); s_bad = pgm_bad; s_rd = rd_cnt; s_rbad = rd_bad;
    s_busy = busy_cyc; s_done = done_cnt; s_viol = viol;
    req = 1'b1; wr = w_r; addr = a; wdata = d;
    @(posedge CP); #1;
    req = 1'b0;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_err_clr", err, 0);
    for (int k = 0; k < 20000 && done_cnt == s_done; k++) begin
      @(posedge CP); #1;
    end
    repeat (3) begin @(posedge CP); #1; end
    ref_mem[a] = exp_after;

    check_eq("done_pulses", done_cnt - s_done, 1);
    check_eq("idle_after", busy, 0);
    check_eq("busy_cycles", busy_cyc - s_busy, seq_cycles(w_r, d));
    n_pgm = pgm_addr_q.size() - s_pgm;
    check_eq("pgm_pulses", n_pgm, idx_list.size());
    for (int k = 0; k < n_pgm && k < idx_list.size(); k++)
      check_eq("pgm_addr", pgm_addr_q[s_pgm + k], idx_list[k]);
    check_eq("pgm_width", pgm_bad - s_bad, 0);
    check_eq("rd_pulses", rd_cnt - s_rd, (!w_r || VERIFY) ? 8 : 0);
    check_eq("rd_width", rd_bad - s_rbad, 0);
    check_eq("strobe_rules", viol - s_viol, 0);
    check_eq("done_rdata", done_rdata, exp_rdata);
    check_eq("done_err", done_err, exp_err);
    $display("op wr=%0d addr=%02h wdata=%02h rdata=%02h err=%0d busy_cyc=%0d pgm=%0d",
             w_r, a, d, done_rdata, done_err, busy_cyc - s_busy, n_pgm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s_pgm, s_done, seen, exp_gap;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[8'h12] = 8'h3C;
    exp_rdata = 8'h00;

    // Reset state
    repeat (3) @(posedge CP);
    #1 check_reset("reset");
    CDN = 1'b1;

    // Directed: read, program A5, read back
    run_op(1'b0, 8'h12, 8'h00);
    run_op(1'b1, 8'h12, 8'hA5);
    run_op(1'b0, 8'h12, 8'h00);

    // Stuck bit 3: program FF, then a request that must clear err
    stuck_en = 1'b1;
    run_op(1'b1, 8'h77, 8'hFF);
    run_op(1'b0, 8'h77, 8'h00);
    stuck_en = 1'b0;

    // Clear asserted 50 cycles into a program strobe
    @(posedge CP); #1;
    req = 1'b1; wr = 1'b1; addr = 8'h55; wdata = 8'h10;
    @(posedge CP); #1;
    req = 1'b0;
    for (int k = 0; k < 200 && !otp_pgm; k++) begin @(posedge CP); #1; end
    check_eq("rst_strobe_seen", otp_pgm, 1);
    repeat (50) @(posedge CP);
    #2 CDN = 1'b0;
    #1 check_reset("rst_mid");
    repeat (2) @(posedge CP);
    #1 CDN = 1'b1;
    exp_rdata = 8'h00;
    run_op(1'b0, 8'h55, 8'h00);

    // req held high across sequences, program of 8'h00
    @(posedge CP); #1;
    s_pgm = pgm_addr_q.size(); s_done = done_cnt; seen = done_cnt;
    exp_gap = seq_cycles(1'b1, 8'h00) + 1;
    req = 1'b1; wr = 1'b1; addr = 8'h60; wdata = 8'h00;
    for (int k = 0; k < 1000 && done_cnt < s_done + 3; k++) begin
      @(posedge CP); #1;
      if (done_cnt != seen) begin
        seen = done_cnt;
        if (seen > s_done + 1) check_eq("held_gap", done_gap, exp_gap);
      end
    end
    req = 1'b0;
    if (VERIFY) exp_rdata = ref_mem[8'h60];
    repeat (4) begin @(posedge CP); #1; end
    check_eq("held_done_cnt", done_cnt - s_done, 3);
    check_eq("held_idle", busy, 0);
    check_eq("held_no_pgm", pgm_addr_q.size() - s_pgm, 0);
    check_eq("held_rdata", rdata, exp_rdata);
    $display("op held-req wr=1 addr=60 wdata=00 dones=%0d gap=%0d", done_cnt - s_done, done_gap);

    // Randomized traffic over a few addresses
    for (int n = 0; n < 10; n++) begin
      logic [7:0] a, d;
      bit w_r;
      a   = 8'h40 + 8'($urandom_range(0, 3));
      d   = 8'($urandom);
      w_r = 1'($urandom_range(0, 1));
      run_op(w_r, a, d);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
